// File: rtl/gold_pkg.sv
// rtl/gold_pkg.sv - shared state encoding and parameter defaults for the gold counter
// Purpose : state enum and parameter defaults used by the gold counter controller,
//           its bus interface and the HUD gold-counter object (which must use the
//           same COUNT_W so the icon count lines up).
// Contents: COUNT_W, DEF_MAX_GOLD, DEF_SPEND_COST, DEF_COOLDOWN_FRAMES,
//           DEF_BLINK_PERIOD_FRAMES (only with GOLD_BLINK_EN), gold_state_t.
// Macro   : GOLD_BLINK_EN enables the HUD blink feature.
package gold_pkg;

  localparam int COUNT_W             = 3;
  localparam int DEF_MAX_GOLD        = 4;
  localparam int DEF_SPEND_COST      = 2;
  localparam int DEF_COOLDOWN_FRAMES = 8;
`ifdef GOLD_BLINK_EN
  localparam int DEF_BLINK_PERIOD_FRAMES = 16;
`endif

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ADD      = 2'd1,
    ST_SPEND    = 2'd2,
    ST_WAIT_REL = 2'd3
  } gold_state_t;

endpackage

// File: rtl/gold_count_ctrl_if.sv
// rtl/gold_count_ctrl_if.sv - game-logic/HUD bus of the gold counter controller
// Purpose : bundles the frame pulse, pickup level, spend handshake and the
//           count outputs of gold_count_ctrl.
// Signals : startOfFrame, gold_hit, spend_req        (game logic -> controller)
//           spend_grant, spend_deny, gold_count,
//           display_count, gold_full, blink          (controller -> game logic/HUD)
// Modports: master = game logic side, slave = gold_count_ctrl.
interface gold_count_ctrl_if;
  import gold_pkg::*;

  logic               startOfFrame;
  logic               gold_hit;
  logic               spend_req;
  logic               spend_grant;
  logic               spend_deny;
  logic [COUNT_W-1:0] gold_count;
  logic [COUNT_W-1:0] display_count;
  logic               gold_full;
  logic               blink;

  modport master (
    output startOfFrame, gold_hit, spend_req,
    input  spend_grant, spend_deny, gold_count, display_count, gold_full, blink
  );

  modport slave (
    input  startOfFrame, gold_hit, spend_req,
    output spend_grant, spend_deny, gold_count, display_count, gold_full, blink
  );

endinterface

// File: rtl/gold_count_ctrl_frame_down_counter.sv
// rtl/gold_count_ctrl_frame_down_counter.sv - loadable per-frame down counter
// Purpose : counts frames down to zero. i_load has priority over i_tick, so a
//           load never decrements in the same cycle. With RELOAD set, a tick
//           while already at zero reloads i_load_val (periodic mode); otherwise
//           the counter parks at zero.
// Ports   : clk, rst_n (async active-low), i_load, i_load_val[W], i_tick,
//           o_zero (count == 0).
module frame_down_counter #(
  parameter int W      = 4,
  parameter bit RELOAD = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_tick,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_tick) begin
      if (r_count != '0) begin
        r_count <= r_count - W'(1);
      end else if (RELOAD) begin
        r_count <= i_load_val;
      end
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/gold_count_ctrl.sv
// rtl/gold_count_ctrl.sv - player gold tally, pickup debounce and spend arbitration
// Purpose : turns multi-cycle gold collision levels into single debounced
//           pickups (edge detect + frame cooldown + one-deep pending slot),
//           arbitrates spend requests with a grant/deny pulse, and publishes a
//           frame-synchronous display count for the HUD counter object.
// Ports   : clk            system clock
//           resetN         asynchronous active-low reset
//           bus (slave)    startOfFrame, gold_hit, spend_req in;
//                          spend_grant, spend_deny, gold_count, display_count,
//                          gold_full, blink out
// Macro   : GOLD_BLINK_EN builds the blink period counter; otherwise blink is 0.
module gold_count_ctrl
  import gold_pkg::*;
#(
  parameter int MAX_GOLD        = DEF_MAX_GOLD,
  parameter int SPEND_COST      = DEF_SPEND_COST,
  parameter int COOLDOWN_FRAMES = DEF_COOLDOWN_FRAMES
`ifdef GOLD_BLINK_EN
  ,
  parameter int BLINK_PERIOD_FRAMES = DEF_BLINK_PERIOD_FRAMES
`endif
) (
  input  logic             clk,
  input  logic             resetN,
  gold_count_ctrl_if.slave bus
);

  // Arithmetic is done one bit wider than the count so +1 at the top cannot wrap
  // before the clamp, and the spend compare sees the true magnitude.
  localparam int CW1  = COUNT_W + 1;
  localparam int CD_W = $clog2(COOLDOWN_FRAMES + 1);
  localparam logic [COUNT_W:0] MAX_EXT  = CW1'(MAX_GOLD);
  localparam logic [COUNT_W:0] COST_EXT = CW1'(SPEND_COST);

  gold_state_t        r_state;
  gold_state_t        w_state_nxt;
  logic [COUNT_W-1:0] r_count;
  logic [COUNT_W-1:0] w_count_nxt;
  logic [COUNT_W-1:0] r_display;
  logic               r_pending;
  logic               w_pending_nxt;
  logic               r_gold_hit_d;
  logic               r_grant;
  logic               w_grant_nxt;
  logic               r_deny;
  logic               w_deny_nxt;
  logic               w_hit_edge;
  logic               w_take_edge;
  logic               w_cd_zero;
  logic               w_cd_load;
  logic               w_full;
  logic [COUNT_W:0]   w_count_ext;
  logic [COUNT_W:0]   w_inc;

  assign w_hit_edge  = bus.gold_hit & ~r_gold_hit_d;
  // Edges inside the cooldown window are dropped outright, never queued.
  assign w_take_edge = w_hit_edge & w_cd_zero;
  assign w_count_ext = {1'b0, r_count};
  assign w_inc       = w_count_ext + CW1'(1);
  assign w_full      = (r_count == COUNT_W'(MAX_GOLD));

  // Cooldown: loaded by ST_ADD, counts frames down, edges accepted only at zero.
  frame_down_counter #(
    .W      (CD_W),
    .RELOAD (1'b0)
  ) u_cooldown (
    .clk        (clk),
    .rst_n      (resetN),
    .i_load     (w_cd_load),
    .i_load_val (CD_W'(COOLDOWN_FRAMES)),
    .i_tick     (bus.startOfFrame),
    .o_zero     (w_cd_zero)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_count_nxt   = r_count;
    w_pending_nxt = r_pending;
    w_grant_nxt   = 1'b0;
    w_deny_nxt    = 1'b0;
    w_cd_load     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        // Pickup wins over a simultaneous spend; the spend request is a held
        // level, so it is picked up again once we are back in idle.
        if (w_take_edge || r_pending) begin
          w_state_nxt = ST_ADD;
        end else if (bus.spend_req) begin
          w_state_nxt = ST_SPEND;
        end
      end
      ST_ADD: begin
        // A pickup while full still consumes the edge and restarts cooldown.
        w_count_nxt   = (w_inc > MAX_EXT) ? COUNT_W'(MAX_EXT) : COUNT_W'(w_inc);
        w_pending_nxt = 1'b0;
        w_cd_load     = 1'b1;
        w_state_nxt   = ST_IDLE;
      end
      ST_SPEND: begin
        if (w_count_ext >= COST_EXT) begin
          w_count_nxt = COUNT_W'(w_count_ext - COST_EXT);
          w_grant_nxt = 1'b1;
        end else begin
          w_deny_nxt  = 1'b1;
        end
        w_state_nxt = ST_WAIT_REL;
      end
      ST_WAIT_REL: begin
        // Holding the request here guarantees it is answered only once.
        if (!bus.spend_req) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // An accepted edge that arrives while busy is parked in the single pending
    // slot; it is applied after the clear above so it is never lost.
    if (w_take_edge && (r_state != ST_IDLE)) begin
      w_pending_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_count      <= '0;
      r_display    <= '0;
      r_pending    <= 1'b0;
      r_gold_hit_d <= 1'b0;
      r_grant      <= 1'b0;
      r_deny       <= 1'b0;
    end else begin
      r_count      <= w_count_nxt;
      r_pending    <= w_pending_nxt;
      r_gold_hit_d <= bus.gold_hit;
      r_grant      <= w_grant_nxt;
      r_deny       <= w_deny_nxt;
      // Samples the registered count, so a coinciding add/spend shows up on
      // the HUD one frame later rather than mid-frame.
      if (bus.startOfFrame) begin
        r_display <= r_count;
      end
    end
  end

`ifdef GOLD_BLINK_EN
  localparam int BL_W = $clog2(BLINK_PERIOD_FRAMES + 1);

  logic w_blink_zero;
  logic r_blink;

  // Held at PERIOD-1 while not full, so the first toggle comes after a full
  // period of frames spent at MAX_GOLD.
  frame_down_counter #(
    .W      (BL_W),
    .RELOAD (1'b1)
  ) u_blink_cnt (
    .clk        (clk),
    .rst_n      (resetN),
    .i_load     (~w_full),
    .i_load_val (BL_W'(BLINK_PERIOD_FRAMES - 1)),
    .i_tick     (bus.startOfFrame),
    .o_zero     (w_blink_zero)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_blink <= 1'b0;
    end else if (!w_full) begin
      r_blink <= 1'b0;
    end else if (bus.startOfFrame && w_blink_zero) begin
      r_blink <= ~r_blink;
    end
  end

  assign bus.blink = r_blink;
`else
  assign bus.blink = 1'b0;
`endif

  assign bus.spend_grant   = r_grant;
  assign bus.spend_deny    = r_deny;
  assign bus.gold_count    = r_count;
  assign bus.display_count = r_display;
  assign bus.gold_full     = w_full;

endmodule

// File: tb/tb_gold_count_ctrl.sv
// tb/tb_gold_count_ctrl.sv - self-checking bench for gold_count_ctrl
// Purpose : directed sequence with randomized hold lengths and a random mixed
//           phase, checked against a transaction-level model of the gold rules.
module tb_gold_count_ctrl;

  localparam int MAX   = 4;
  localparam int COST  = 2;
  localparam int CDF   = 8;
  localparam int BLINK = 16;
`ifdef GOLD_BLINK_EN
  localparam bit BLINK_ON = 1'b1;
`else
  localparam bit BLINK_ON = 1'b0;
`endif

  logic clk;
  logic resetN;
  gold_count_ctrl_if bus ();

  gold_count_ctrl dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Model: tally, frames of cooldown left, frames spent at full.
  int m_gold = 0;
  int m_cd   = 0;
  int m_full_frames = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_blink();
    return BLINK_ON ? ((m_full_frames / BLINK) % 2) : 0;
  endfunction

  task automatic do_frames(input int n);
    for (int i = 0; i < n; i++) begin
      bus.startOfFrame = 1'b1;
      step();
      bus.startOfFrame = 1'b0;
      if (m_cd > 0) m_cd--;
      if (m_gold == MAX) m_full_frames++;
      check("display_count", bus.display_count, m_gold);
      check("blink", bus.blink, exp_blink());
    end
  endtask

  task automatic do_pickup(input int hold);
    bus.gold_hit = 1'b1;
    repeat (hold) step();
    bus.gold_hit = 1'b0;
    if (hold < 2) repeat (2 - hold) step();
    if (m_cd == 0) begin
      m_gold = (m_gold + 1 > MAX) ? MAX : m_gold + 1;
      m_cd   = CDF;
    end
    check("pickup_count", bus.gold_count, m_gold);
    check("pickup_full", bus.gold_full, (m_gold == MAX));
    step();
  endtask

  task automatic do_spend(input int extra);
    bit exp_grant;
    exp_grant = (m_gold >= COST);
    bus.spend_req = 1'b1;
    step();
    check("spend_early", bus.spend_grant | bus.spend_deny, 0);
    step();
    check("spend_grant", bus.spend_grant, exp_grant);
    check("spend_deny", bus.spend_deny, !exp_grant);
    if (exp_grant) m_gold -= COST;
    if (m_gold != MAX) m_full_frames = 0;
    check("spend_count", bus.gold_count, m_gold);
    step();
    check("pulse_end", bus.spend_grant | bus.spend_deny, 0);
    for (int i = 0; i < extra; i++) begin
      step();
      check("no_second_pulse", bus.spend_grant | bus.spend_deny, 0);
    end
    bus.spend_req = 1'b0;
    step();
    step();
    check("spend_blink", bus.blink, exp_blink());
  endtask

  initial begin
    bus.startOfFrame = 1'b0;
    bus.gold_hit     = 1'b0;
    bus.spend_req    = 1'b0;
    resetN           = 1'b0;
    repeat (3) step();

    // Reset state
    check("rst_count", bus.gold_count, 0);
    check("rst_display", bus.display_count, 0);
    check("rst_full", bus.gold_full, 0);
    check("rst_grant", bus.spend_grant, 0);
    check("rst_deny", bus.spend_deny, 0);
    check("rst_blink", bus.blink, 0);
    resetN = 1'b1;
    step();

    // Long collision level yields exactly one pickup
    do_pickup(500);
    check("hold_count", bus.gold_count, 1);
    check("display_before_frame", bus.display_count, 0);
    do_frames(10);

    // Spaced pickups up to saturation and one past it
    for (int i = 0; i < 4; i++) begin
      do_pickup($urandom_range(1, 5));
      do_frames(10);
    end
    check("saturated", bus.gold_count, MAX);

    // Grant from 4, refill to 3, grant with long hold, then deny at 1
    do_spend(0);
    do_frames(10);
    do_pickup(1);
    check("three", bus.gold_count, 3);
    do_spend(20);
    check("after_grant", bus.gold_count, 1);
    do_spend(3);
    check("after_deny", bus.gold_count, 1);

    // Simultaneous pickup and spend at count 2: add first, then spend
    do_frames(10);
    do_pickup(2);
    do_frames(10);
    bus.gold_hit  = 1'b1;
    bus.spend_req = 1'b1;
    step();
    bus.gold_hit = 1'b0;
    step();
    m_gold = m_gold + 1;
    m_cd   = CDF;
    check("sim_add_first", bus.gold_count, m_gold);
    check("sim_no_grant_yet", bus.spend_grant | bus.spend_deny, 0);
    step();
    step();
    m_gold = m_gold - COST;
    check("sim_grant", bus.spend_grant, 1);
    check("sim_final", bus.gold_count, m_gold);
    step();
    check("sim_pulse_end", bus.spend_grant, 0);
    bus.spend_req = 1'b0;
    step();
    step();

    // Pickup during wait-for-release goes to pending, served after release
    do_frames(10);
    bus.spend_req = 1'b1;
    step();
    step();
    check("wr_deny", bus.spend_deny, (m_gold < COST));
    step();
    bus.gold_hit = 1'b1;
    step();
    bus.gold_hit = 1'b0;
    repeat (4) step();
    check("wr_held", bus.gold_count, m_gold);
    check("wr_no_pulse", bus.spend_grant | bus.spend_deny, 0);
    bus.spend_req = 1'b0;
    repeat (3) step();
    m_gold = (m_gold + 1 > MAX) ? MAX : m_gold + 1;
    m_cd   = CDF;
    check("pending_served", bus.gold_count, m_gold);
    step();
    do_frames(2);
    do_pickup(2);
    check("cooldown_ignored", bus.gold_count, m_gold);

    // Random mixed phase
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 2))
        0: do_pickup($urandom_range(1, 6));
        1: do_spend($urandom_range(0, 4));
        default: do_frames($urandom_range(0, 12));
      endcase
    end

    // Fill up, dwell at full across blink periods, then spend out of full
    do_frames(10);
    while (m_gold < MAX) begin
      do_pickup($urandom_range(1, 3));
      do_frames(10);
    end
    do_frames(20);
    do_spend(0);
    check("blink_cleared", bus.blink, 0);

    // Reset asserted while a spend is being evaluated
    do_frames(10);
    bus.spend_req = 1'b1;
    step();
    resetN = 1'b0;
    #1;
    m_gold = 0;
    m_cd = 0;
    m_full_frames = 0;
    check("midrst_count", bus.gold_count, 0);
    check("midrst_display", bus.display_count, 0);
    check("midrst_pulse", bus.spend_grant | bus.spend_deny, 0);
    check("midrst_full", bus.gold_full, 0);
    check("midrst_blink", bus.blink, 0);
    step();
    step();
    check("midrst_pulse_hold", bus.spend_grant | bus.spend_deny, 0);
    bus.spend_req = 1'b0;
    resetN = 1'b1;
    step();
    step();
    check("postrst_pulse", bus.spend_grant | bus.spend_deny, 0);
    check("postrst_count", bus.gold_count, 0);
    do_pickup(3);
    do_frames(1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
